// File: rtl/compressor_pwm.sv
// Slow-PWM compressor driver with minimum on/off time protection.
// A signed Q8.8 PID output sets an 8-bit duty; a lock FSM prevents short cycling.
module compressor_pwm #(
  parameter int PRESCALE      = 100,
  parameter int MIN_ON_TICKS  = 60000,
  parameter int MIN_OFF_TICKS = 60000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic signed [15:0] pid_out,
  output logic               comp_on,
  output logic [7:0]         duty,
  output logic [1:0]         state,
  output logic               short_cycle_block
);

  typedef enum logic [1:0] {
    OFF_LOCK = 2'd0,
    IDLE     = 2'd1,
    ON_LOCK  = 2'd2,
    RUN      = 2'd3
  } state_t;

  localparam int              PW            = $clog2(PRESCALE);
  localparam logic [PW-1:0]   PRESCALE_LAST = PW'(PRESCALE - 1);
  localparam logic [15:0]     ON_LAST       = 16'(MIN_ON_TICKS - 1);
  localparam logic [15:0]     OFF_LAST      = 16'(MIN_OFF_TICKS - 1);

  logic [PW-1:0] r_presc;
  logic [7:0]    r_phase;
  logic          r_enable_d;
  logic [7:0]    r_duty;
  logic [15:0]   r_timer;
  state_t        r_state;
  logic          r_comp_on;
  logic          r_scb;

  logic          w_tick;
  logic          w_period_start;
  logic [16:0]   w_demand;
  logic [9:0]    w_demand_shr;
  logic [7:0]    w_duty_next;
  logic          w_pwm_req;
  state_t        w_next;
  logic          w_comp_on_next;
  logic          w_scb_next;

  assign w_tick         = (r_presc == PRESCALE_LAST);
  assign w_period_start = (enable && !r_enable_d) || (w_tick && (r_phase == 8'd255));

  // Demand is the magnitude of negative PID output; positive output means no cooling.
  assign w_demand     = pid_out[15] ? (17'd0 - {pid_out[15], pid_out}) : 17'd0;
  assign w_demand_shr = 10'(w_demand >> 7);
  assign w_duty_next  = (|w_demand_shr[9:8]) ? 8'hFF : w_demand_shr[7:0];

  assign w_pwm_req = enable && (r_phase < r_duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_phase    <= 8'd0;
      r_enable_d <= 1'b0;
      r_duty     <= 8'd0;
    end else begin
      r_presc    <= w_tick ? '0 : r_presc + PW'(1);
      r_enable_d <= enable;
      if (!enable) begin
        r_phase <= 8'd0;
        r_duty  <= 8'd0;
      end else begin
        if (w_tick)
          r_phase <= r_phase + 8'd1;
        if (w_period_start)
          r_duty <= w_duty_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= OFF_LOCK;
      r_timer   <= 16'd0;
      r_comp_on <= 1'b0;
      r_scb     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_comp_on <= w_comp_on_next;
      r_scb     <= w_scb_next;
      if (w_next != r_state)
        r_timer <= 16'd0;
      else if (w_tick && (r_state == OFF_LOCK || r_state == ON_LOCK))
        r_timer <= r_timer + 16'd1;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      OFF_LOCK: if (w_tick && (r_timer == OFF_LAST)) w_next = IDLE;
      IDLE:     if (w_pwm_req)                       w_next = ON_LOCK;
      ON_LOCK:  if (w_tick && (r_timer == ON_LAST))  w_next = RUN;
      RUN:      if (!w_pwm_req)                      w_next = OFF_LOCK;
      default:                                       w_next = OFF_LOCK;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the transition.
  always_comb begin
    w_comp_on_next = (w_next == ON_LOCK) || (w_next == RUN);
    w_scb_next     = ((w_next == OFF_LOCK) && w_pwm_req) ||
                     ((w_next == ON_LOCK) && !w_pwm_req);
  end

  assign comp_on           = r_comp_on;
  assign duty              = r_duty;
  assign state             = r_state;
  assign short_cycle_block = r_scb;

endmodule

// File: tb/tb_compressor_pwm.sv
// Directed bench for compressor_pwm with PRESCALE=4, MIN_ON_TICKS=8, MIN_OFF_TICKS=8.
// Edge numbers count rising clk edges since the last reset release; outputs are sampled on the falling edge.
module tb_compressor_pwm;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic signed [15:0] pid_out;
  logic               comp_on;
  logic [7:0]         duty;
  logic [1:0]         state;
  logic               short_cycle_block;

  int checks = 0;
  int errors = 0;
  int cyc;

  compressor_pwm #(
    .PRESCALE      (4),
    .MIN_ON_TICKS  (8),
    .MIN_OFF_TICKS (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .pid_out           (pid_out),
    .comp_on           (comp_on),
    .duty              (duty),
    .state             (state),
    .short_cycle_block (short_cycle_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic gotoEdge(input int n);
    int guard;
    guard = 0;
    while (cyc < n) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        errors++;
        $display("[TB] FAIL timeout waiting for edge %0d observed=%0d expected=%0d", n, cyc, n);
        $fatal(1, "[TB] timeout");
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    pid_out = 16'sh0000;
    #23;
    checkOutput("rst_comp_on", 16'(comp_on), 16'd0);
    checkOutput("rst_duty", 16'(duty), 16'd0);
    checkOutput("rst_state", 16'(state), 16'd0);
    checkOutput("rst_scb", 16'(short_cycle_block), 16'd0);

    // Power-up lockout with enable low
    @(negedge clk);
    rst_n = 1'b1;
    gotoEdge(31);
    checkOutput("lock_state_e31", 16'(state), 16'd0);
    checkOutput("lock_comp_e31", 16'(comp_on), 16'd0);
    checkOutput("lock_duty_e31", 16'(duty), 16'd0);
    gotoEdge(32);
    checkOutput("idle_state_e32", 16'(state), 16'd1);

    // Half-duty operation: pid -64.0
    enable  = 1'b1;
    pid_out = 16'shC000;
    gotoEdge(33);
    checkOutput("half_duty_e33", 16'(duty), 16'd128);
    checkOutput("half_comp_e33", 16'(comp_on), 16'd0);
    gotoEdge(34);
    checkOutput("half_comp_e34", 16'(comp_on), 16'd1);
    checkOutput("half_state_e34", 16'(state), 16'd2);
    checkOutput("half_scb_e34", 16'(short_cycle_block), 16'd0);
    gotoEdge(64);
    checkOutput("half_run_e64", 16'(state), 16'd3);
    gotoEdge(300);
    pid_out = 16'sh8000;
    gotoEdge(544);
    checkOutput("half_comp_e544", 16'(comp_on), 16'd1);
    checkOutput("half_state_e544", 16'(state), 16'd3);
    checkOutput("midperiod_duty_e544", 16'(duty), 16'd128);
    gotoEdge(545);
    checkOutput("half_comp_e545", 16'(comp_on), 16'd0);
    checkOutput("half_state_e545", 16'(state), 16'd0);
    checkOutput("half_scb_e545", 16'(short_cycle_block), 16'd0);
    gotoEdge(577);
    checkOutput("half_idle_e577", 16'(state), 16'd1);
    gotoEdge(1056);
    checkOutput("full_duty_e1056", 16'(duty), 16'd255);
    checkOutput("full_comp_e1056", 16'(comp_on), 16'd0);
    checkOutput("full_scb_e1056", 16'(short_cycle_block), 16'd0);
    gotoEdge(1057);
    checkOutput("full_comp_e1057", 16'(comp_on), 16'd1);
    checkOutput("full_state_e1057", 16'(state), 16'd2);
    gotoEdge(1090);
    checkOutput("full_run_e1090", 16'(state), 16'd3);

    // One-cycle enable drop while running
    enable = 1'b0;
    gotoEdge(1091);
    checkOutput("drop_comp_e1091", 16'(comp_on), 16'd0);
    checkOutput("drop_state_e1091", 16'(state), 16'd0);
    checkOutput("drop_duty_e1091", 16'(duty), 16'd0);
    enable = 1'b1;
    gotoEdge(1092);
    checkOutput("reen_duty_e1092", 16'(duty), 16'd255);
    checkOutput("reen_scb_e1092", 16'(short_cycle_block), 16'd0);
    gotoEdge(1093);
    checkOutput("reen_scb_e1093", 16'(short_cycle_block), 16'd1);
    checkOutput("reen_comp_e1093", 16'(comp_on), 16'd0);
    gotoEdge(1119);
    checkOutput("reen_state_e1119", 16'(state), 16'd0);
    checkOutput("reen_comp_e1119", 16'(comp_on), 16'd0);
    checkOutput("reen_scb_e1119", 16'(short_cycle_block), 16'd1);
    gotoEdge(1120);
    checkOutput("reen_state_e1120", 16'(state), 16'd1);
    checkOutput("reen_scb_e1120", 16'(short_cycle_block), 16'd0);
    gotoEdge(1121);
    checkOutput("reen_comp_e1121", 16'(comp_on), 16'd1);
    checkOutput("reen_state_e1121", 16'(state), 16'd2);

    // Asynchronous reset in the middle of ON_LOCK
    gotoEdge(1125);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_comp", 16'(comp_on), 16'd0);
    checkOutput("arst_state", 16'(state), 16'd0);
    checkOutput("arst_duty", 16'(duty), 16'd0);
    checkOutput("arst_scb", 16'(short_cycle_block), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    gotoEdge(1);
    checkOutput("post_duty_e1", 16'(duty), 16'd255);
    gotoEdge(2);
    checkOutput("post_scb_e2", 16'(short_cycle_block), 16'd1);
    gotoEdge(31);
    checkOutput("post_state_e31", 16'(state), 16'd0);
    checkOutput("post_comp_e31", 16'(comp_on), 16'd0);
    gotoEdge(32);
    checkOutput("post_state_e32", 16'(state), 16'd1);
    gotoEdge(33);
    checkOutput("post_comp_e33", 16'(comp_on), 16'd1);

    // Positive PID output gives zero duty and no start
    rst_n   = 1'b0;
    pid_out = 16'sh0500;
    @(negedge clk);
    rst_n = 1'b1;
    gotoEdge(40);
    checkOutput("zero_duty_e40", 16'(duty), 16'd0);
    checkOutput("zero_state_e40", 16'(state), 16'd1);
    checkOutput("zero_comp_e40", 16'(comp_on), 16'd0);

    // Duty 2 forces a full minimum on-time with short-cycle flag
    enable  = 1'b0;
    pid_out = 16'shFF00;
    gotoEdge(41);
    enable = 1'b1;
    gotoEdge(42);
    checkOutput("d2_duty_e42", 16'(duty), 16'd2);
    gotoEdge(43);
    checkOutput("d2_comp_e43", 16'(comp_on), 16'd1);
    checkOutput("d2_state_e43", 16'(state), 16'd2);
    checkOutput("d2_scb_e43", 16'(short_cycle_block), 16'd0);
    gotoEdge(48);
    checkOutput("d2_scb_e48", 16'(short_cycle_block), 16'd0);
    gotoEdge(49);
    checkOutput("d2_scb_e49", 16'(short_cycle_block), 16'd1);
    gotoEdge(71);
    checkOutput("d2_state_e71", 16'(state), 16'd2);
    checkOutput("d2_scb_e71", 16'(short_cycle_block), 16'd1);
    gotoEdge(72);
    checkOutput("d2_state_e72", 16'(state), 16'd3);
    checkOutput("d2_comp_e72", 16'(comp_on), 16'd1);
    checkOutput("d2_scb_e72", 16'(short_cycle_block), 16'd0);
    gotoEdge(73);
    checkOutput("d2_comp_e73", 16'(comp_on), 16'd0);
    checkOutput("d2_state_e73", 16'(state), 16'd0);
    gotoEdge(103);
    checkOutput("d2_state_e103", 16'(state), 16'd0);
    checkOutput("d2_comp_e103", 16'(comp_on), 16'd0);
    gotoEdge(104);
    checkOutput("d2_state_e104", 16'(state), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/compressor_pwm.md
COMPRESSOR_PWM -- requirements
Module: compressor_pwm

Interface
REQ-001 SHALL have parameter PRESCALE, default 100, meaning clk cycles per PWM tick (range 2..65535).
REQ-002 SHALL have parameter MIN_ON_TICKS, default 60000, meaning minimum compressor on-time in ticks (range 1..65535).
REQ-003 SHALL have parameter MIN_OFF_TICKS, default 60000, meaning minimum compressor off-time in ticks (range 1..65535).
REQ-004 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port enable  input  1  cooling permitted.
REQ-007 SHALL have port pid_out  input  16  signed Q8.8 PID controller output.
REQ-008 SHALL have port comp_on  output  1  compressor drive, registered.
REQ-009 SHALL have port duty  output  8  duty code latched for the current PWM period.
REQ-010 SHALL have port state  output  2  FSM state: 0 OFF_LOCK, 1 IDLE, 2 ON_LOCK, 3 RUN.
REQ-011 SHALL have port short_cycle_block  output  1  demand overridden by a min-time lock, registered.

Function
REQ-012 SHALL keep a free-running prescaler 0..PRESCALE-1, independent of enable; tick = one-cycle pulse when the prescaler equals PRESCALE-1, after which it wraps to 0.
REQ-013 SHALL keep an 8-bit phase counter: held at 0 while enable=0; while enable=1 it increments on each tick, wrapping 255->0.
REQ-014 SHALL generate period_start on the first cycle enable is seen high after low (registered enable_d=0, enable=1), or on a tick with phase=255.
REQ-015 SHALL compute demand d (17-bit unsigned) = -pid_out if pid_out<0, else 0; duty_next = min(255, d>>7); e.g. -16384 -> 128, -32768 -> 255.
REQ-016 SHALL load duty from duty_next only on period_start; changes to pid_out mid-period have no effect; duty SHALL be 0 while enable=0.
REQ-017 SHALL define pwm_req = enable AND (phase < duty); duty=0 means never requested.
REQ-018 SHALL keep a 16-bit lock timer, cleared on every state entry, incremented on each tick in OFF_LOCK and ON_LOCK.
REQ-019 OFF_LOCK: comp_on=0; on a tick with timer=MIN_OFF_TICKS-1 go to IDLE.
REQ-020 IDLE: comp_on=0; if pwm_req go to ON_LOCK (comp_on rises on the same edge).
REQ-021 ON_LOCK: comp_on=1 regardless of enable/pwm_req; on a tick with timer=MIN_ON_TICKS-1 go to RUN.
REQ-022 RUN: comp_on=1; if pwm_req=0 (including enable=0) go to OFF_LOCK (comp_on falls on the same edge).
REQ-023 comp_on SHALL be the registered decode of next state, no combinational path from inputs.
REQ-024 short_cycle_block SHALL be registered as (next state OFF_LOCK and pwm_req) or (next state ON_LOCK and not pwm_req).
REQ-025 SHALL resolve simultaneous events in one cycle: an ON_LOCK or OFF_LOCK expiry tick coinciding with period_start uses the already-latched phase/duty for pwm_req in that cycle; IDLE->ON_LOCK and RUN->OFF_LOCK evaluation uses current pwm_req only.

Reset
REQ-026 On rst_n low SHALL immediately set comp_on=0, duty=0, state=OFF_LOCK, short_cycle_block=0, prescaler=0, phase=0, timer=0, enable_d=0, independent of clk.
REQ-027 After reset release SHALL enforce the full MIN_OFF_TICKS lockout before any compressor start (power-up protection).

Verification (PRESCALE=4, MIN_ON_TICKS=8, MIN_OFF_TICKS=8)
REQ-028 Reset release, enable=0 -> comp_on=0, duty=0, state=OFF_LOCK for 32 clk, then state=IDLE.
REQ-029 After IDLE, pid_out=16'hC000 (-64.0), enable=1 -> duty=128; comp_on high for 128 ticks (512 clk), low for 128 ticks, repeating; short_cycle_block never set.
REQ-030 pid_out=16'h8000 -> duty=255; pid_out=16'h0500 -> duty=0, comp_on stays 0, state stays IDLE.
REQ-031 duty=2 from IDLE -> comp_on high for exactly 8 ticks (ON_LOCK), short_cycle_block high from tick 2 to 7, then RUN->OFF_LOCK and comp_on low for at least 8 ticks.
REQ-032 In RUN, drop enable for one cycle with pid_out=16'h8000 -> comp_on low next edge, state OFF_LOCK; re-enable -> short_cycle_block=1, comp_on stays 0 for 8 ticks, then start on the first tick where pwm_req=1.
REQ-033 Assert rst_n low mid-ON_LOCK between clock edges -> comp_on=0 within the same time step, state=OFF_LOCK, full 8-tick lockout after release.
